// File: rtl/fifo_collector.sv
// Round-robin collector: serially reads one WORD_BITS word at a time from the
// selected block FIFO and holds it on a valid/ready output until accepted.
module fifo_collector #(
    parameter int NUM_BLOCKS   = 24,
    parameter int WORD_BITS    = 64,
    parameter int READ_LATENCY = 2
) (
    input  logic                  fifo_clk,
    input  logic                  fifo_rst,
    input  logic [1:NUM_BLOCKS]   fifo_empty,
    output logic [1:NUM_BLOCKS]   fifo_req,
    input  logic                  fifo_bit,
    output logic [WORD_BITS-1:0]  out_data,
    output logic [4:0]            out_index,
    output logic                  out_valid,
    input  logic                  out_ready
);
    localparam int CW = $clog2(WORD_BITS + 1);
    localparam int SW = $clog2(NUM_BLOCKS + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, HOLD} stateT;

    stateT                 r_state;
    logic [4:0]            r_lastServed;
    logic [4:0]            r_index;
    logic [1:NUM_BLOCKS]   r_mask;
    logic [1:NUM_BLOCKS]   r_req;
    logic [CW-1:0]         r_reqCount;
    logic [CW-1:0]         r_bitCount;
    logic [READ_LATENCY:1] r_dly;
    logic [WORD_BITS-1:0]  r_shift;
    logic                  r_valid;

    logic                  w_grantFound;
    logic [4:0]            w_grantIdx;
    logic [1:NUM_BLOCKS]   w_grantMask;
    logic                  w_capture;

    // Block number 'offset' positions after 'last', wrapping NUM_BLOCKS back to 1.
    function automatic logic [SW-1:0] rrCandidate(input logic [4:0] last, input int offset);
        int c;
        c = int'(last) + offset;
        if (c > NUM_BLOCKS) c = c - NUM_BLOCKS;
        return SW'(c);
    endfunction

    // Scanning from the far end lets the nearest non-empty block win.
    always_comb begin
        w_grantFound = 1'b0;
        w_grantIdx   = '0;
        w_grantMask  = '0;
        for (int k = NUM_BLOCKS; k >= 1; k--) begin
            if (!fifo_empty[rrCandidate(r_lastServed, k)]) begin
                w_grantFound = 1'b1;
                w_grantIdx   = 5'(rrCandidate(r_lastServed, k));
                w_grantMask  = '0;
                w_grantMask[rrCandidate(r_lastServed, k)] = 1'b1;
            end
        end
    end

    assign w_capture = r_dly[READ_LATENCY];

    always_ff @(posedge fifo_clk or posedge fifo_rst) begin
        if (fifo_rst) begin
            r_state      <= IDLE;
            r_lastServed <= 5'(NUM_BLOCKS);
            r_index      <= '0;
            r_mask       <= '0;
            r_req        <= '0;
            r_reqCount   <= '0;
            r_bitCount   <= '0;
            r_dly        <= '0;
            r_shift      <= '0;
            r_valid      <= 1'b0;
        end else begin
            r_dly[1] <= |r_req;
            for (int i = 2; i <= READ_LATENCY; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
            if (w_capture) begin
                r_shift    <= {r_shift[WORD_BITS-2:0], fifo_bit};
                r_bitCount <= r_bitCount + CW'(1);
            end
            case (r_state)
                IDLE: begin
                    if (w_grantFound) begin
                        r_state      <= SHIFT;
                        r_index      <= w_grantIdx;
                        r_lastServed <= w_grantIdx;
                        r_mask       <= w_grantMask;
                        r_reqCount   <= '0;
                        r_bitCount   <= '0;
                    end
                end
                SHIFT: begin
                    // The request register trails the count by one cycle, so the
                    // last request cycle is the one in which the count reads WORD_BITS.
                    if (r_reqCount == CW'(WORD_BITS)) begin
                        r_req   <= '0;
                        r_state <= DRAIN;
                    end else begin
                        r_req      <= r_mask;
                        r_reqCount <= r_reqCount + CW'(1);
                    end
                end
                DRAIN: begin
                    if (w_capture && (r_bitCount == CW'(WORD_BITS - 1))) begin
                        r_state <= HOLD;
                        r_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign fifo_req  = r_req;
    assign out_data  = r_shift;
    assign out_index = r_index;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_fifo_collector.sv
// Randomised bench for fifo_collector: behavioural block FIFOs feed serial bits,
// a round-robin reference model predicts grants and the words delivered.
module tb_fifo_collector;
    localparam int N    = 24;
    localparam int W    = 64;
    localparam int L    = 2;
    localparam int WB   = $clog2(W);
    localparam int MAXC = 65536;

    logic          fifo_clk   = 1'b0;
    logic          fifo_rst   = 1'b0;
    logic [1:N]    fifo_empty = '1;
    logic [1:N]    fifo_req;
    logic          fifo_bit   = 1'b0;
    logic [W-1:0]  out_data;
    logic [4:0]    out_index;
    logic          out_valid;
    logic          out_ready  = 1'b0;

    fifo_collector #(.NUM_BLOCKS(N), .WORD_BITS(W), .READ_LATENCY(L)) dut (
        .fifo_clk  (fifo_clk),
        .fifo_rst  (fifo_rst),
        .fifo_empty(fifo_empty),
        .fifo_req  (fifo_req),
        .fifo_bit  (fifo_bit),
        .out_data  (out_data),
        .out_index (out_index),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 fifo_clk = ~fifo_clk;

    typedef struct {
        int           idx;
        logic [W-1:0] word;
        int           riseCyc;
    } expT;

    int           testsRun = 0;
    int           testsFailed = 0;
    logic [W-1:0] blkQ [1:N][$];
    int           blkPtr [1:N];
    bit           bitPipe [$];
    expT          expQ [$];
    logic [1:N]   emptyLog [0:MAXC-1];
    int           idxLog [$];
    int           cyc = 0;
    int           modelLast = N;
    int           reqLen = 0;
    int           lastRise = -1;
    int           validLen = 0;
    int           lastValidLen = 0;
    int           handshakes = 0;
    int           lastIdx = 0;
    logic [W-1:0] lastData = '0;
    logic [1:N]   prevReq = '0;
    logic         prevValid = 1'b0;
    logic         prevReady = 1'b0;
    logic [W-1:0] holdData = '0;
    logic [4:0]   holdIdx = '0;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, actual, expected, $time);
        end
    endtask

    // Round-robin choice straight from the rule: first non-empty block after 'last'.
    function automatic int rrPick(input int last, input logic [1:N] emp);
        for (int k = 1; k <= N; k++) begin
            int b;
            b = (last + k - 1) % N + 1;
            if (!emp[5'(b)]) return b;
        end
        return 0;
    endfunction

    function automatic logic [1:N] oneHot(input int b);
        logic [1:N] m;
        m = '0;
        if (b >= 1 && b <= N) m[5'(b)] = 1'b1;
        return m;
    endfunction

    function automatic bit pending();
        for (int b = 1; b <= N; b++) begin
            if (blkQ[b].size() > 0) return 1'b1;
        end
        return expQ.size() > 0;
    endfunction

    task automatic applyStimulus(input int blk, input logic [W-1:0] word);
        blkQ[blk].push_back(word);
    endtask

    task automatic waitDone(input int budget);
        int n;
        n = 0;
        while ((pending() || out_valid || fifo_req != '0) && n < budget) begin
            @(posedge fifo_clk);
            #2;
            n++;
        end
        checkOutput("drainInBudget", 64'(n < budget), 64'(1));
    endtask

    // Block model, serial data path and all cycle-level checks live here so that
    // everything the DUT samples changes at the falling edge only.
    always @(negedge fifo_clk) begin
        logic [1:N]   reqNow;
        int           pick;
        logic         bitOr;
        logic [W-1:0] w;
        expT          e;
        reqNow = fifo_req;
        if (fifo_rst) begin
            checkOutput("rstQuiet", 64'({reqNow != '0, out_valid}), 64'(0));
            modelLast = N;
            expQ.delete();
            bitPipe.delete();
            for (int i = 0; i < L; i++) bitPipe.push_back(1'b0);
            fifo_bit = 1'b0;
            for (int b = 1; b <= N; b++) blkPtr[b] = 0;
            prevReq   = '0;
            prevValid = 1'b0;
            prevReady = 1'b0;
            reqLen    = 0;
            validLen  = 0;
            lastRise  = -1;
        end else begin
            checkOutput("reqOneHot", 64'($countones(reqNow) <= 1), 64'(1));
            if (reqNow != '0 && prevReq == '0) begin
                pick = rrPick(modelLast, (cyc >= 2) ? emptyLog[cyc-2] : '1);
                checkOutput("grantIdx", 64'(reqNow), 64'(oneHot(pick)));
                if (pick != 0) begin
                    modelLast = pick;
                    e.idx     = pick;
                    e.word    = (blkQ[pick].size() > 0) ? blkQ[pick][0] : '0;
                    e.riseCyc = cyc;
                    expQ.push_back(e);
                end
                reqLen = 1;
            end else if (reqNow != '0) begin
                checkOutput("reqSteady", 64'(reqNow), 64'(prevReq));
                reqLen++;
            end else if (prevReq != '0) begin
                checkOutput("reqLength", 64'(reqLen), 64'(W));
            end
            if (out_valid) checkOutput("reqInHold", 64'(reqNow), 64'(0));

            bitOr = 1'b0;
            for (int b = 1; b <= N; b++) begin
                if (reqNow[5'(b)] && blkQ[b].size() > 0) begin
                    w = blkQ[b][0];
                    bitOr = bitOr | w[WB'(W - 1 - blkPtr[b])];
                    blkPtr[b]++;
                    if (blkPtr[b] == W) begin
                        void'(blkQ[b].pop_front());
                        blkPtr[b] = 0;
                    end
                end
            end
            bitPipe.push_back(bitOr);
            fifo_bit = bitPipe.pop_front();

            if (prevValid) checkOutput("validAfterReady", 64'(out_valid), 64'(!prevReady));
            if (out_valid && !prevValid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedWord", 64'(1), 64'(0));
                end else begin
                    e = expQ.pop_front();
                    checkOutput("latency", 64'(cyc - e.riseCyc), 64'(W + L));
                    checkOutput("outIndex", 64'(out_index), 64'(e.idx));
                    checkOutput("outData", out_data, e.word);
                end
                if (lastRise >= 0) checkOutput("wordSpacing", 64'((cyc - lastRise) >= W + L + 2), 64'(1));
                lastRise = cyc;
                holdData = out_data;
                holdIdx  = out_index;
                lastData = out_data;
                lastIdx  = int'(out_index);
                idxLog.push_back(int'(out_index));
                validLen = 0;
            end else if (out_valid) begin
                checkOutput("holdData", out_data, holdData);
                checkOutput("holdIndex", 64'(out_index), 64'(holdIdx));
            end
            if (out_valid) validLen++;
            if (out_valid && out_ready) begin
                handshakes++;
                lastValidLen = validLen;
            end
            prevReq   = reqNow;
            prevValid = out_valid;
            prevReady = out_ready;
        end
        for (int b = 1; b <= N; b++) fifo_empty[5'(b)] = (blkQ[b].size() == 0);
        if (cyc < MAXC) emptyLog[cyc] = fifo_empty;
        cyc++;
    end

    initial begin
        int           n;
        int           hsBefore;
        bit           sawActivity;
        int           expSeq [4];
        logic [W-1:0] word;

        #1 fifo_rst = 1'b1;
        repeat (3) @(posedge fifo_clk);
        #1;
        checkOutput("rstReq", 64'(fifo_req), 64'(0));
        checkOutput("rstValid", 64'(out_valid), 64'(0));
        checkOutput("rstData", out_data, 64'(0));
        checkOutput("rstIndex", 64'(out_index), 64'(0));
        #1 fifo_rst = 1'b0;
        out_ready = 1'b1;

        // Nothing to collect: the outputs must stay quiet.
        sawActivity = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge fifo_clk);
            #2;
            sawActivity = sawActivity | (fifo_req != '0) | out_valid;
        end
        checkOutput("idleQuiet", 64'(sawActivity), 64'(0));

        applyStimulus(5, 64'hDEADBEEF_01234567);
        waitDone(500);
        checkOutput("blk5Index", 64'(lastIdx), 64'(5));
        checkOutput("blk5Data", lastData, 64'hDEADBEEF_01234567);

        applyStimulus(24, 64'hA5A5_0000_FFFF_1234);
        waitDone(500);
        checkOutput("blk24First", 64'(lastIdx), 64'(24));
        applyStimulus(24, 64'h0123_4567_89AB_CDEF);
        waitDone(500);
        checkOutput("blk24Wrap", 64'(lastIdx), 64'(24));
        checkOutput("blk24WrapData", lastData, 64'h0123_4567_89AB_CDEF);

        idxLog.delete();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(3, {$urandom, $urandom});
            applyStimulus(20, {$urandom, $urandom});
        end
        waitDone(2000);
        expSeq = '{3, 20, 3, 20};
        for (int k = 0; k < 4; k++) begin
            checkOutput("rrSequence", 64'((idxLog.size() > k) ? idxLog[k] : -1), 64'(expSeq[k]));
        end

        // Back-pressure: keep the word waiting ten cycles before accepting it.
        out_ready = 1'b0;
        hsBefore = handshakes;
        applyStimulus(7, {$urandom, $urandom});
        n = 0;
        while (!out_valid && n < 300) begin
            @(posedge fifo_clk);
            #1;
            n++;
        end
        checkOutput("holdArrived", 64'(out_valid), 64'(1));
        repeat (10) @(posedge fifo_clk);
        #2 out_ready = 1'b1;
        waitDone(100);
        checkOutput("holdLength", 64'(lastValidLen), 64'(11));
        checkOutput("holdTransfers", 64'(handshakes - hsBefore), 64'(1));

        // Reset in the middle of a word: the partial word must vanish.
        word = 64'hCAFE_F00D_1357_9BDF;
        hsBefore = handshakes;
        applyStimulus(11, word);
        n = 0;
        while (fifo_req == '0 && n < 300) begin
            @(posedge fifo_clk);
            #1;
            n++;
        end
        checkOutput("shiftStarted", 64'(fifo_req != '0), 64'(1));
        repeat (29) @(posedge fifo_clk);
        #2 fifo_rst = 1'b1;
        #1;
        checkOutput("rstClearsReq", 64'(fifo_req), 64'(0));
        checkOutput("rstNoValid", 64'(out_valid), 64'(0));
        @(posedge fifo_clk);
        #2 fifo_rst = 1'b0;
        waitDone(500);
        checkOutput("afterRstIndex", 64'(lastIdx), 64'(11));
        checkOutput("afterRstData", lastData, word);
        checkOutput("afterRstTransfers", 64'(handshakes - hsBefore), 64'(1));

        for (int i = 0; i < 2500; i++) begin
            @(posedge fifo_clk);
            #2;
            if ($urandom_range(79, 0) == 0) applyStimulus(int'($urandom_range(N, 1)), {$urandom, $urandom});
            out_ready = ($urandom_range(3, 0) != 0);
        end
        out_ready = 1'b1;
        waitDone(20000);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: time limit reached, %0d tests run, %0d failed", testsRun, testsFailed);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/fifo_collector.md
FIFO_COLLECTOR -- requirements
Module: fifo_collector

Interface
REQ-001 Parameter NUM_BLOCKS, default 24, number of block FIFO ports, indexed 1..NUM_BLOCKS.
REQ-002 Parameter WORD_BITS, default 64, bits per result word read from one block.
REQ-003 Parameter READ_LATENCY, default 2, fifo_clk cycles from a fifo_req cycle to its bit on fifo_bit.
REQ-004 fifo_clk  in  1  sole clock; one clock, all logic on its rising edge.
REQ-005 fifo_rst  in  1  reset, asynchronous, active-high.
REQ-006 fifo_empty  in  [1:NUM_BLOCKS]  per-block FIFO empty flag, fifo_clk domain.
REQ-007 fifo_req  out  [1:NUM_BLOCKS]  per-block shift request; one bit shifted out per asserted cycle.
REQ-008 fifo_bit  in  1  registered OR of all block serial outputs.
REQ-009 out_data  out  WORD_BITS  assembled word, MSB first.
REQ-010 out_index  out  5  block index (1..NUM_BLOCKS) that sourced out_data.
REQ-011 out_valid  out  1  out_data/out_index valid.
REQ-012 out_ready  in  1  downstream accepts the word when out_valid and out_ready are both high.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT, DRAIN and HOLD.
REQ-014 In IDLE, the grant SHALL go to the first block with fifo_empty low, searching round-robin from last_served+1 and wrapping NUM_BLOCKS->1; last_served resets to NUM_BLOCKS.
REQ-015 In IDLE with all fifo_empty high, the FSM SHALL stay in IDLE with fifo_req all zero.
REQ-016 On grant, the FSM SHALL enter SHIFT on the next edge, latch the granted index, and update last_served.
REQ-017 In SHIFT, exactly one fifo_req bit (the granted one) SHALL be high for exactly WORD_BITS consecutive cycles, then the FSM SHALL enter DRAIN.
REQ-018 fifo_req SHALL be registered, at most one bit high at any time, and zero outside SHIFT.
REQ-019 A READ_LATENCY-deep delay line of the request SHALL qualify capture: each qualified cycle shifts fifo_bit into the LSB of a WORD_BITS shift register.
REQ-020 DRAIN SHALL last until WORD_BITS bits are captured (READ_LATENCY cycles), then enter HOLD.
REQ-021 In HOLD, out_valid SHALL be high; out_data and out_index SHALL stay stable until the handshake.
REQ-022 On handshake, out_valid SHALL drop the next cycle and the FSM SHALL return to IDLE.
REQ-023 A fifo_empty change during SHIFT, DRAIN or HOLD SHALL be ignored; the word is always completed.
REQ-024 Latency: from the IDLE grant edge to out_valid high SHALL be 1+WORD_BITS+READ_LATENCY cycles.
REQ-025 The captured-bit counter SHALL be ceil(log2(WORD_BITS+1)) bits wide and never wrap within a word.
REQ-026 Throughput SHALL be at most one word per WORD_BITS+READ_LATENCY+2 cycles.

Reset
REQ-027 While fifo_rst is high: state=IDLE, fifo_req=0, out_valid=0, out_data=0, out_index=0, counter=0, delay line=0, last_served=NUM_BLOCKS.
REQ-028 Reset asserted mid-SHIFT SHALL clear fifo_req asynchronously and discard the partial word; no out_valid SHALL follow.
REQ-029 After reset release, the first grant SHALL use round-robin order starting at block 1.

Verification
REQ-030 Only block 5 non-empty, block model returns 0xDEADBEEF_01234567 MSB first at latency 2 -> fifo_req[5] high 64 cycles; out_data=0xDEADBEEF01234567, out_index=5, out_valid at grant+67.
REQ-031 Blocks 3 and 20 non-empty continuously, out_ready=1 -> out_index sequence 3,20,3,20; fifo_req never has two bits high.
REQ-032 Word in HOLD, out_ready=0 for 10 cycles, then 1 -> out_valid held 11 cycles, data stable, one transfer, no fifo_req during HOLD.
REQ-033 fifo_rst pulsed at SHIFT cycle 30 -> fifo_req=0 immediately, out_valid stays 0; the next word is complete and correct.
REQ-034 Block 24 non-empty only, after serving block 24 -> wrap to search from 1; grant 24 again; out_index=24.
REQ-035 All empty for 100 cycles -> fifo_req=0 and out_valid=0 throughout.
